// File: rtl/barrel_unshift.sv
// Sequential inverse of the byte rotator: undoes an amt-position rotation one bit per clock.
// Define BARREL_UNSHIFT_FAST_EN to rotate two bits per clock while at least two remain.
module barrel_unshift #(
    parameter int unsigned W  = 8,
    parameter int unsigned AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  a,
    input  logic [AW-1:0] amt,
    input  logic          direction,
    output logic          ready,
    output logic          done,
    output logic [W-1:0]  y
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  wr_q, wr_d;
    logic [W-1:0]  y_q, y_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          dl_q, dl_d;
    logic [W-1:0]  wr_rot;
    logic [AW-1:0] cnt_nxt;

    // One step of the inverse rotation: opposite to the latched original direction.
    always_comb begin
`ifdef BARREL_UNSHIFT_FAST_EN
        if (cnt_q >= AW'(2)) begin
            wr_rot  = dl_q ? {wr_q[1:0], wr_q[W-1:2]} : {wr_q[W-3:0], wr_q[W-1:W-2]};
            cnt_nxt = cnt_q - AW'(2);
        end else begin
            wr_rot  = dl_q ? {wr_q[0], wr_q[W-1:1]} : {wr_q[W-2:0], wr_q[W-1]};
            cnt_nxt = cnt_q - AW'(1);
        end
`else
        wr_rot  = dl_q ? {wr_q[0], wr_q[W-1:1]} : {wr_q[W-2:0], wr_q[W-1]};
        cnt_nxt = cnt_q - AW'(1);
`endif
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        dl_d    = dl_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    wr_d  = a;
                    cnt_d = amt;
                    dl_d  = direction;
                    if (amt == '0) begin
                        state_d = StDone;
                        y_d     = a;
                    end else begin
                        state_d = StShift;
                    end
                end
            end
            StShift: begin
                wr_d  = wr_rot;
                cnt_d = cnt_nxt;
                if (cnt_nxt == '0) begin
                    state_d = StDone;
                    y_d     = wr_rot;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            wr_q    <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            dl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            dl_q    <= dl_d;
        end
    end

    assign ready = (state_q == StIdle);
    assign done  = (state_q == StDone);
    assign y     = y_q;

endmodule

// File: tb/tb_barrel_unshift.sv
// Directed bench for barrel_unshift; expected results are hand-computed rotations.
module tb_barrel_unshift;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = 8'h00;
    logic [2:0] amt = 3'd0;
    logic       direction = 1'b0;
    logic       ready;
    logic       done;
    logic [7:0] y;

    int n_vec = 0;
    int n_err = 0;

    barrel_unshift #(.W(8), .AW(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .amt       (amt),
        .direction (direction),
        .ready     (ready),
        .done      (done),
        .y         (y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Edge (accept = 1) at which DONE is entered.
    function automatic int done_edge(input int n);
`ifdef BARREL_UNSHIFT_FAST_EN
        return (n + 1) / 2 + 1;
`else
        return n + 1;
`endif
    endfunction

    task automatic run_op(input logic [7:0] av, input logic [2:0] amtv, input logic dv,
                          input logic [7:0] yexp, input bit poke);
        int k;
        @(negedge clk);
        a = av; amt = amtv; direction = dv; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = ~av; amt = ~amtv; direction = ~dv;
        chk("ready_low", ready, 0);
        k = 1;
        while (!done && k < 20) begin
            if (poke && k == 2) begin
                start = 1'b1; a = 8'hFF; amt = 3'd1; direction = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk("done_seen", done, 1);
        chk("latency", k, done_edge(amtv));
        chk("y", y, yexp);
        chk("rdy_done_excl", ready & done, 0);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("ready_back", ready, 1);
        chk("y_hold", y, yexp);
    endtask

    initial begin
        int n;
        int k;
        int t1;
        #12;
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_y", y, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        run_op(8'hA5, 3'd3, 1'b1, 8'hB4, 1'b0);
        run_op(8'h2D, 3'd2, 1'b0, 8'hB4, 1'b0);
        run_op(8'h5A, 3'd0, 1'b1, 8'h5A, 1'b0);
        run_op(8'h5A, 3'd0, 1'b0, 8'h5A, 1'b0);
        run_op(8'h5A, 3'd7, 1'b1, 8'hB4, 1'b1);
        run_op(8'h81, 3'd1, 1'b0, 8'h03, 1'b0);

        // Asynchronous reset during SHIFT of amt=6.
        @(negedge clk);
        a = 8'h33; amt = 3'd6; direction = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_ready", ready, 1);
        chk("arst_y", y, 8'h00);
        chk("arst_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) n++;
        end
        chk("no_done_after_rst", n, 0);
        run_op(8'hA5, 3'd3, 1'b1, 8'hB4, 1'b0);

        // start held high across two operations.
        @(negedge clk);
        a = 8'hA5; amt = 3'd3; direction = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 8'h2D; amt = 3'd2; direction = 1'b0;
        k = 1;
        while (!done && k < 40) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        chk("b2b_done1", done, 1);
        chk("b2b_lat1", k, done_edge(3));
        chk("b2b_y1", y, 8'hB4);
        t1 = k;
        @(posedge clk);
        @(negedge clk);
        k++;
        chk("b2b_ready", ready, 1);
        while (!done && k < 40) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk("b2b_done2", done, 1);
        chk("b2b_sep", k - t1, done_edge(2) + 1);
        chk("b2b_y2", y, 8'hB4);
        @(negedge clk);
        @(negedge clk);
        chk("b2b_idle", ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/barrel_unshift.md
# barrel_unshift

Sequential inverse of the combinational byte rotator: takes a byte already rotated by `amt` positions in direction `direction` and restores the original byte. It rotates one bit per clock in the opposite direction under a start/ready/done handshake. It sits on the receive side of the rotate datapath and recovers operands scrambled by the barrel rotator.

## Interface
Parameters:
- `W`, 8, data width; fixed at 8 for this revision.
- `AW`, 3, amount width; equals log2(`W`).

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only while `ready`=1.
- `a`  in  W  rotated input byte; captured when `start` is accepted.
- `amt`  in  AW  rotation amount originally applied, 0..7; captured with `a`.
- `direction`  in  1  original rotation direction: 1 = rotated left, 0 = rotated right; captured with `a`.
- `ready`  out  1  high only in IDLE.
- `done`  out  1  one-cycle pulse when `y` holds a new result.
- `y`  out  W  restored byte; registered.

## Operation
- Internal state: FSM, working register `wr[7:0]`, down-counter `cnt[2:0]`, latched direction `dl`.
- IDLE:
  - `ready`=1.
  - On `start`=1: load `wr`=`a`, `cnt`=`amt`, `dl`=`direction`.
  - Next state is DONE if `amt`=0, otherwise SHIFT.
- SHIFT:
  - Each cycle, rotate `wr` by one bit opposite to `dl`:
    - `dl`=1: rotate right, `wr` <= {wr[0], wr[7:1]}.
    - `dl`=0: rotate left, `wr` <= {wr[6:0], wr[7]}.
  - Decrement `cnt`. When `cnt`=1 at the edge, go to DONE.
- DONE:
  - `done`=1 for exactly this cycle; `y` <= `wr` on entry.
  - Unconditionally return to IDLE on the next edge.
- `y` changes only when DONE is entered and holds its value until the next DONE. The intermediate `wr` is never visible on `y`.
- `start` while not in IDLE is ignored: not queued, and no effect on captured operands.
- Inputs `a`, `amt` and `direction` are don't-care except on the accept edge.
- Rotation is pure: no bits are lost or filled, and all arithmetic is modulo 8.

## Timing
- Reset (asynchronous, any time, including mid-SHIFT):
  - FSM enters IDLE immediately; the in-flight operation is aborted with no `done`.
  - `ready`=1, `done`=0, `y`=8'h00, `wr`=0, `cnt`=0.
- Latency, counting the `start`-accept edge as edge 1:
  - The DONE state is entered at edge `amt`+1.
  - `done` is high during the cycle after that edge.
  - `amt`=0 gives `done` in the cycle right after accept.
- Throughput: one operation per `amt`+2 cycles. `ready` returns high the cycle after `done`.
- Back-to-back: `start` held high is accepted again on the first IDLE cycle.
- `ready` and `done` are never high in the same cycle.

## Configuration
- `BARREL_UNSHIFT_FAST_EN` defined:
  - SHIFT rotates by 2 bits per cycle when `cnt`>=2, by 1 otherwise, decrementing `cnt` accordingly.
  - DONE is entered at edge ceil(`amt`/2)+1.
  - Results, handshake and reset behaviour are identical.
- Undefined: one bit per cycle, as described above.

## Test plan
- Reset, then `a`=8'hA5, `amt`=3, `direction`=1, pulse `start` -> `ready` low; `done` high in the cycle after edge 4 (FAST: after edge 3), `y`=8'hB4.
- `a`=8'h2D, `amt`=2, `direction`=0 -> `y`=8'hB4; exactly one `done` pulse; `ready` high the cycle after.
- `a`=8'h5A, `amt`=0, either direction -> `done` in the cycle after accept, `y`=8'h5A.
- `a`=8'h5A, `amt`=7, `direction`=1 -> `y`=8'hB4 after edge 8 (FAST: after edge 5); a `start` pulse mid-operation with `a`=8'hFF is ignored and the result stays 8'hB4.
- Assert `reset` asynchronously during SHIFT of `amt`=6 -> `ready`=1 and `y`=8'h00 immediately, and no `done` follows; a fresh `a`=8'hA5, `amt`=3, `direction`=1 then completes normally with `y`=8'hB4.
- Hold `start` high across two operations (8'hA5/3/1 then 8'h2D/2/0) -> two `done` pulses separated by `amt`+2 cycles, `y`=8'hB4 both times.
